// File: rtl/game_ctrl.sv
// game_ctrl: sequencing controller for a two-sided ship battle game.
// Flow: DECISION -> COLOCATION -> SETUP -> PLAYER_TURN <-> PC_TURN -> VICTORY/DEFEAT.
// Optional feature macro: GAME_CTRL_TURN_TIMEOUT_EN enables the per-turn timer
// that forces a handoff after TURN_TIMEOUT idle cycles. Without it the timer
// outputs are tied low and turns end only by a move.
// Every output comes from a flop. The state one-hot decode is registered from
// the next-state value, so it always agrees with the state output.
module game_ctrl #(
  parameter int MAX_SHIPS    = 5,
  parameter int TURN_TIMEOUT = 1000,
  parameter int TURN_W       = 8,
  localparam int CW = $clog2(MAX_SHIPS + 1),
  localparam int TW = $clog2(TURN_TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              ships_decided,
  input  logic [CW-1:0]     ship_count_sel,
  input  logic              ship_placed,
  input  logic              finished_setUp,
  input  logic              player_has_move,
  input  logic              pc_has_move,
  input  logic              player_sank,
  input  logic              pc_sank,
  output logic [2:0]        state,
  output logic              decision_State,
  output logic              colocation_ships_State,
  output logic              setup_State,
  output logic              player_turn_State,
  output logic              pc_turn_State,
  output logic              is_victory_State,
  output logic              is_defeat_State,
  output logic [CW-1:0]     player_ships_left,
  output logic [CW-1:0]     pc_ships_left,
  output logic [CW-1:0]     ships_placed,
  output logic [TURN_W-1:0] turn_count,
  output logic [TW-1:0]     turn_timer,
  output logic              timeout_flag
);

  typedef enum logic [2:0] {
    S_DECISION    = 3'd0,
    S_COLOCATION  = 3'd1,
    S_SETUP       = 3'd2,
    S_PLAYER_TURN = 3'd3,
    S_PC_TURN     = 3'd4,
    S_VICTORY     = 3'd5,
    S_DEFEAT      = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        onehot_q;
  logic [CW-1:0]     ship_cnt_q, ship_cnt_d;
  logic [CW-1:0]     pl_left_q, pl_left_d;
  logic [CW-1:0]     pc_left_q, pc_left_d;
  logic [CW-1:0]     placed_q, placed_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic              handoff;

`ifdef GAME_CTRL_TURN_TIMEOUT_EN
  logic [TW-1:0] timer_q, timer_d;
  logic          flag_q;
  logic          timer_expired;
  logic          timeout_now;

  assign timer_expired = (timer_q == TW'(TURN_TIMEOUT - 1));
`endif

  // Next-state and counter updates; restart wins over every game input.
  always_comb begin
    state_d    = state_q;
    ship_cnt_d = ship_cnt_q;
    pl_left_d  = pl_left_q;
    pc_left_d  = pc_left_q;
    placed_d   = placed_q;
    turn_cnt_d = turn_cnt_q;
    handoff    = 1'b0;
`ifdef GAME_CTRL_TURN_TIMEOUT_EN
    timeout_now = 1'b0;
`endif
    if (restart) begin
      state_d    = S_DECISION;
      pl_left_d  = '0;
      pc_left_d  = '0;
      placed_d   = '0;
      turn_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_DECISION: begin
          if (ships_decided && (ship_count_sel != '0) &&
              (ship_count_sel <= CW'(MAX_SHIPS))) begin
            ship_cnt_d = ship_count_sel;
            pl_left_d  = ship_count_sel;
            pc_left_d  = ship_count_sel;
            placed_d   = '0;
            state_d    = S_COLOCATION;
          end
        end
        S_COLOCATION: begin
          if (ship_placed && (placed_q < ship_cnt_q)) begin
            placed_d = placed_q + CW'(1);
            if (placed_q + CW'(1) == ship_cnt_q) state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          if (finished_setUp) begin
            state_d    = S_PLAYER_TURN;
            turn_cnt_d = '0;
          end
        end
        S_PLAYER_TURN: begin
          if (player_sank && (pc_left_q != '0)) pc_left_d = pc_left_q - CW'(1);
          if (player_sank && (pc_left_q == CW'(1))) begin
            state_d = S_VICTORY;
          end else if (player_has_move) begin
            state_d = S_PC_TURN;
            handoff = 1'b1;
          end
`ifdef GAME_CTRL_TURN_TIMEOUT_EN
          else if (timer_expired) begin
            state_d     = S_PC_TURN;
            handoff     = 1'b1;
            timeout_now = 1'b1;
          end
`endif
        end
        S_PC_TURN: begin
          if (pc_sank && (pl_left_q != '0)) pl_left_d = pl_left_q - CW'(1);
          if (pc_sank && (pl_left_q == CW'(1))) begin
            state_d = S_DEFEAT;
          end else if (pc_has_move) begin
            state_d = S_PLAYER_TURN;
            handoff = 1'b1;
          end
`ifdef GAME_CTRL_TURN_TIMEOUT_EN
          else if (timer_expired) begin
            state_d     = S_PLAYER_TURN;
            handoff     = 1'b1;
            timeout_now = 1'b1;
          end
`endif
        end
        default: ; // VICTORY / DEFEAT: everything frozen until restart
      endcase
      if (handoff && (turn_cnt_q != '1)) turn_cnt_d = turn_cnt_q + TURN_W'(1);
    end
  end

  // State and game counters; rst has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DECISION;
      onehot_q   <= 7'b000_0001;
      ship_cnt_q <= '0;
      pl_left_q  <= '0;
      pc_left_q  <= '0;
      placed_q   <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      onehot_q   <= 7'b000_0001 << state_d;
      ship_cnt_q <= ship_cnt_d;
      pl_left_q  <= pl_left_d;
      pc_left_q  <= pc_left_d;
      placed_q   <= placed_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

`ifdef GAME_CTRL_TURN_TIMEOUT_EN
  // Timer runs only while staying in the same turn state, so any turn entry,
  // handoff, restart or game end clears it.
  always_comb begin
    timer_d = '0;
    if (((state_d == S_PLAYER_TURN) || (state_d == S_PC_TURN)) && (state_d == state_q))
      timer_d = timer_q + TW'(1);
  end

  // Timer and one-cycle timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      flag_q  <= timeout_now;
    end
  end

  assign turn_timer   = timer_q;
  assign timeout_flag = flag_q;
`else
  assign turn_timer   = '0;
  assign timeout_flag = 1'b0;
`endif

  assign state                  = state_q;
  assign decision_State         = onehot_q[0];
  assign colocation_ships_State = onehot_q[1];
  assign setup_State            = onehot_q[2];
  assign player_turn_State      = onehot_q[3];
  assign pc_turn_State          = onehot_q[4];
  assign is_victory_State       = onehot_q[5];
  assign is_defeat_State        = onehot_q[6];
  assign player_ships_left      = pl_left_q;
  assign pc_ships_left          = pc_left_q;
  assign ships_placed           = placed_q;
  assign turn_count             = turn_cnt_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl. The driver applies one input
// vector per cycle, advances a game-rule model and queues the expected output
// snapshot; an independent monitor pops and compares after every rising edge.
module tb_game_ctrl;
  localparam int MAX_SHIPS    = 5;
  localparam int TURN_TIMEOUT = 4;
  localparam int TURN_W       = 3;
  localparam int CW = $clog2(MAX_SHIPS + 1);
  localparam int TW = $clog2(TURN_TIMEOUT);
  localparam int W  = 3 + 7 + 3 * CW + TURN_W + TW + 1;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, restart = 1'b0, ships_decided = 1'b0, ship_placed = 1'b0;
  logic finished_setUp = 1'b0, player_has_move = 1'b0, pc_has_move = 1'b0;
  logic player_sank = 1'b0, pc_sank = 1'b0;
  logic [CW-1:0] ship_count_sel = '0;
  logic [2:0] state;
  logic decision_State, colocation_ships_State, setup_State, player_turn_State;
  logic pc_turn_State, is_victory_State, is_defeat_State, timeout_flag;
  logic [CW-1:0] player_ships_left, pc_ships_left, ships_placed;
  logic [TURN_W-1:0] turn_count;
  logic [TW-1:0] turn_timer;

  game_ctrl #(.MAX_SHIPS(MAX_SHIPS), .TURN_TIMEOUT(TURN_TIMEOUT), .TURN_W(TURN_W)) dut (
    .clk(clk), .rst(rst), .restart(restart), .ships_decided(ships_decided),
    .ship_count_sel(ship_count_sel), .ship_placed(ship_placed),
    .finished_setUp(finished_setUp), .player_has_move(player_has_move),
    .pc_has_move(pc_has_move), .player_sank(player_sank), .pc_sank(pc_sank),
    .state(state), .decision_State(decision_State),
    .colocation_ships_State(colocation_ships_State), .setup_State(setup_State),
    .player_turn_State(player_turn_State), .pc_turn_State(pc_turn_State),
    .is_victory_State(is_victory_State), .is_defeat_State(is_defeat_State),
    .player_ships_left(player_ships_left), .pc_ships_left(pc_ships_left),
    .ships_placed(ships_placed), .turn_count(turn_count),
    .turn_timer(turn_timer), .timeout_flag(timeout_flag)
  );

  // ---------------- reference model (game rules) ----------------
  localparam int DEC = 0, COL = 1, SET = 2, PT = 3, CT = 4, VIC = 5, DEF = 6;
`ifdef GAME_CTRL_TURN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic rst, restart, decided;
    logic [CW-1:0] sel;
    logic placed, fin, pmove, cmove, psank, csank;
  } stim_t;

  int m_ph, m_ships, m_pl, m_pc, m_placed, m_tc, m_tmr, m_flag;

  task automatic turn_pass(input int next_ph, input bit by_timeout);
    m_ph   = next_ph;
    m_tc   = (m_tc < (1 << TURN_W) - 1) ? m_tc + 1 : m_tc;
    m_tmr  = 0;
    m_flag = by_timeout ? 1 : 0;
  endtask

  task automatic model_step(input stim_t s);
    int sel;
    sel = int'(s.sel);
    if (s.rst) begin
      m_ph = DEC; m_ships = 0; m_pl = 0; m_pc = 0; m_placed = 0;
      m_tc = 0; m_tmr = 0; m_flag = 0;
      return;
    end
    m_flag = 0;
    if (s.restart) begin
      m_ph = DEC; m_pl = 0; m_pc = 0; m_placed = 0; m_tc = 0; m_tmr = 0;
      return;
    end
    case (m_ph)
      DEC: if (s.decided && sel >= 1 && sel <= MAX_SHIPS) begin
        m_ships = sel; m_pl = sel; m_pc = sel; m_placed = 0; m_ph = COL;
      end
      COL: if (s.placed) begin
        m_placed++;
        if (m_placed == m_ships) m_ph = SET;
      end
      SET: if (s.fin) begin m_ph = PT; m_tc = 0; m_tmr = 0; end
      PT: begin
        if (s.psank && m_pc > 0) m_pc--;
        if (s.psank && m_pc == 0) begin m_ph = VIC; m_tmr = 0; end
        else if (s.pmove) turn_pass(CT, 0);
        else if (TMO_EN && m_tmr == TURN_TIMEOUT - 1) turn_pass(CT, 1);
        else if (TMO_EN) m_tmr++;
      end
      CT: begin
        if (s.csank && m_pl > 0) m_pl--;
        if (s.csank && m_pl == 0) begin m_ph = DEF; m_tmr = 0; end
        else if (s.cmove) turn_pass(PT, 0);
        else if (TMO_EN && m_tmr == TURN_TIMEOUT - 1) turn_pass(PT, 1);
        else if (TMO_EN) m_tmr++;
      end
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] model_snapshot();
    logic [6:0] oh;
    oh = 7'b100_0000 >> m_ph;
    return {3'(m_ph), oh, CW'(m_pl), CW'(m_pc), CW'(m_placed),
            TURN_W'(m_tc), TW'(m_tmr), 1'(m_flag)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0;

  // Monitor: the DUT presents a fresh output snapshot after every edge.
  initial begin
    logic [W-1:0] obs, exp_v;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        obs = {state, decision_State, colocation_ships_State, setup_State,
               player_turn_State, pc_turn_State, is_victory_State, is_defeat_State,
               player_ships_left, pc_ships_left, ships_placed, turn_count,
               turn_timer, timeout_flag};
        n_tests++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %h expected %h", cyc, obs, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input stim_t s);
    @(negedge clk);
    rst = s.rst; restart = s.restart; ships_decided = s.decided;
    ship_count_sel = s.sel; ship_placed = s.placed; finished_setUp = s.fin;
    player_has_move = s.pmove; pc_has_move = s.cmove;
    player_sank = s.psank; pc_sank = s.csank;
    model_step(s);
    exp_q.push_back(model_snapshot());
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(nop());
  endtask

  task automatic do_rst();     stim_t s; s = nop(); s.rst = 1'b1;     step(s); endtask
  task automatic do_restart(); stim_t s; s = nop(); s.restart = 1'b1; step(s); endtask
  task automatic do_place();   stim_t s; s = nop(); s.placed = 1'b1;  step(s); endtask
  task automatic do_fin();     stim_t s; s = nop(); s.fin = 1'b1;     step(s); endtask
  task automatic do_decide(input int sel);
    stim_t s; s = nop(); s.decided = 1'b1; s.sel = CW'(sel); step(s);
  endtask
  task automatic do_turn(input bit pm, input bit cm, input bit ps, input bit cs);
    stim_t s; s = nop(); s.pmove = pm; s.cmove = cm; s.psank = ps; s.csank = cs; step(s);
  endtask
  task automatic setup_game(input int n);
    do_decide(n);
    for (int i = 0; i < n; i++) do_place();
    do_fin();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_rst();
    idle(2);
    // Decision filtering, placement limit, first handoffs.
    do_decide(0);
    do_decide(3);
    do_place(); do_place(); do_place(); do_place();
    do_fin();
    do_turn(1, 0, 0, 0);
    do_turn(0, 1, 0, 0);
    idle(1);
    // Single-ship game: sink and move together ends in VICTORY.
    do_restart();
    setup_game(1);
    do_turn(1, 0, 1, 0);
    do_turn(1, 1, 1, 1);
    idle(2);
    do_restart();
    // Two ships: off-turn pc_sank ignored, then DEFEAT.
    setup_game(2);
    do_turn(0, 0, 0, 1);
    do_turn(1, 0, 0, 0);
    do_turn(0, 0, 0, 1);
    do_turn(0, 0, 0, 1);
    idle(2);
    do_restart();
    // Max boundary: sel above MAX ignored, sel = MAX accepted; idle turn.
    do_decide(MAX_SHIPS + 1);
    setup_game(MAX_SHIPS);
    idle(TURN_TIMEOUT + 3);
    // turn_count saturation.
    for (int i = 0; i < 10; i++) do_turn(1, 1, 0, 0);
    idle(1);
    // Reset mid-game discards progress, and inputs held during reset are ignored.
    begin
      stim_t s;
      s = '1; s.sel = CW'(2);
      step(s);
    end
    idle(1);
    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s = nop();
      s.rst     = ($urandom_range(0, 299) == 0);
      s.restart = ($urandom_range(0, 79) == 0);
      s.decided = ($urandom_range(0, 2) == 0);
      s.sel     = CW'($urandom_range(0, (1 << CW) - 1));
      s.placed  = ($urandom_range(0, 1) == 0);
      s.fin     = ($urandom_range(0, 2) == 0);
      s.pmove   = ($urandom_range(0, 5) == 0);
      s.cmove   = ($urandom_range(0, 5) == 0);
      s.psank   = ($urandom_range(0, 7) == 0);
      s.csank   = ($urandom_range(0, 7) == 0);
      step(s);
    end
    idle(1);
    @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter MAX_SHIPS, 5, maximum ships per side (1..15).
REQ-002 Parameter TURN_TIMEOUT, 1000, cycles allowed per turn before forced handoff (>=2).
REQ-003 Parameter TURN_W, 8, width of turn counter.
REQ-004 Derived: CW = $clog2(MAX_SHIPS+1); TW = $clog2(TURN_TIMEOUT).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 restart  in  1  pulse, return to DECISION from any state.
REQ-008 ships_decided  in  1  pulse, latch ship_count_sel.
REQ-009 ship_count_sel  in  CW  requested ships per side.
REQ-010 ship_placed  in  1  pulse, one player ship placed.
REQ-011 finished_setUp  in  1  pulse, setup complete.
REQ-012 player_has_move / pc_has_move  in  1 each  turn-ending move pulses.
REQ-013 player_sank / pc_sank  in  1 each  pulse, opponent ship sunk this cycle.
REQ-014 state  out  3  encoded: DECISION=0, COLOCATION=1, SETUP=2, PLAYER_TURN=3, PC_TURN=4, VICTORY=5, DEFEAT=6.
REQ-015 decision_State, colocation_ships_State, setup_State, player_turn_State, pc_turn_State, is_victory_State, is_defeat_State  out  1 each  one-hot decode of state.
REQ-016 player_ships_left / pc_ships_left  out  CW each  remaining ships.
REQ-017 ships_placed  out  CW  ships placed so far.
REQ-018 turn_count  out  TURN_W  completed turn handoffs.
REQ-019 turn_timer  out  TW  cycles elapsed in current turn.
REQ-020 timeout_flag  out  1  one-cycle pulse on forced handoff.

Function
REQ-021 All outputs registered; state change visible one cycle after qualifying input edge.
REQ-022 DECISION: ships_decided with 1<=ship_count_sel<=MAX_SHIPS -> latch ship_count, both *_ships_left := sel, ships_placed := 0, go COLOCATION; sel 0 or >MAX_SHIPS ignored, stay.
REQ-023 COLOCATION: each ship_placed increments ships_placed; pulse making ships_placed == ship_count -> SETUP; ships_placed never exceeds ship_count.
REQ-024 SETUP: finished_setUp -> PLAYER_TURN, turn_timer := 0, turn_count := 0.
REQ-025 PLAYER_TURN: player_sank decrements pc_ships_left (saturate 0); decrement reaching 0 -> VICTORY, overriding simultaneous move/timeout.
REQ-026 PLAYER_TURN: otherwise player_has_move -> PC_TURN; sank + move same cycle applies decrement and hands off.
REQ-027 PC_TURN: symmetric; pc_sank decrements player_ships_left; reaching 0 -> DEFEAT; else pc_has_move -> PLAYER_TURN.
REQ-028 Sank/move inputs of the non-active side ignored; all game inputs ignored outside their state.
REQ-029 Each PLAYER_TURN<->PC_TURN handoff (move or timeout) increments turn_count, saturating at all-ones.
REQ-030 turn_timer counts cycles in turn states, cleared on every turn entry, held 0 elsewhere.
REQ-031 VICTORY/DEFEAT: hold, all counters frozen, until restart.
REQ-032 restart (any state): next state DECISION, ship counters, ships_placed, turn_count, turn_timer cleared; rst has priority over restart.

Reset
REQ-033 rst high at clock edge: state DECISION, decision_State=1, all other outputs 0; held while rst high.
REQ-034 rst mid-game discards all progress; no input sampled while rst high.

Configuration
REQ-035 Macro GAME_CTRL_TURN_TIMEOUT_EN defined: turn_timer reaching TURN_TIMEOUT-1 with no move/sank-to-zero forces handoff next edge, pulses timeout_flag, increments turn_count; move on that same cycle is a normal handoff, no timeout_flag.
REQ-036 Macro undefined: no timer logic; turn_timer and timeout_flag tied 0; turns end only by move.

Verification
REQ-037 rst 1 cycle -> state=0, decision_State=1, all counters 0.
REQ-038 sel=0 + ships_decided -> stays DECISION; sel=3 + ships_decided -> COLOCATION, both ships_left=3; 3 ship_placed -> SETUP, ships_placed=3; 4th pulse no effect.
REQ-039 finished_setUp, then player_has_move, pc_has_move -> PLAYER_TURN, PC_TURN, PLAYER_TURN; turn_count=2.
REQ-040 sel=1, player_sank with player_has_move same cycle -> VICTORY, pc_ships_left=0, turn_count unchanged; restart -> DECISION.
REQ-041 sel=2, two pc_sank in PC_TURN -> DEFEAT; pc_sank during PLAYER_TURN leaves player_ships_left unchanged.
REQ-042 With GAME_CTRL_TURN_TIMEOUT_EN, TURN_TIMEOUT=4, idle PLAYER_TURN -> PC_TURN after 4 cycles, timeout_flag 1 cycle; without macro stays PLAYER_TURN.
